// File: rtl/uart_tx_if.sv
// Byte handshake plus serial line and status for the UART transmitter.
// The driver asserts tx_valid until tx_ready accepts; status signals come from the transmitter.
interface uart_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx, busy, done
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx, busy, done
  );
endinterface

// File: rtl/uart_tx.sv
// UART frame serialiser (start, 8 data LSB first, optional parity, stop), two clk_2br cycles per bit.
// tx falls the cycle after accept; tx_ready is low for the whole frame, and requests are held off, not queued.
module uart_tx #(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic     clk_2br,
  input  logic     reset,
  uart_tx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       phase_q, phase_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] hold_q, hold_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       accept;
  logic       par_d;

  assign accept = bus.tx_valid && (state_q == IDLE);

  always_ff @(posedge clk_2br or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      bit_idx_q <= 3'd0;
      hold_q    <= 8'd0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      hold_q    <= hold_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    hold_d    = hold_q;
    case (state_q)
      IDLE: begin
        phase_d   = 1'b0;
        bit_idx_d = 3'd0;
        if (accept) begin
          hold_d  = bus.tx_data;
          state_d = START;
        end
      end
      START: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          state_d = STOP;
        end
      end
      STOP: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        phase_d   = 1'b0;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // tx is decoded from the next state so the line level is registered and changes on the same edge as the state.
  always_comb begin
    par_d  = (^hold_d) ^ PARITY_ODD;
    tx_d   = 1'b1;
    done_d = (state_q == STOP) && phase_q;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = hold_d[bit_idx_d];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.tx       = tx_q;
  assign bus.done     = done_q;
  assign bus.tx_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: even, odd and no-parity instances share one clock and reset.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       vld [3];
  logic [7:0] dat [3];
  logic       o_tx [3];
  logic       o_rdy [3];
  logic       o_busy [3];
  logic       o_done [3];

  int n_chk;
  int n_fail;

  uart_tx_if ife ();
  uart_tx_if ifo ();
  uart_tx_if ifn ();

  uart_tx dut_e (.clk_2br(clk), .reset(reset), .bus(ife));
  uart_tx #(.PARITY_ODD(1'b1)) dut_o (.clk_2br(clk), .reset(reset), .bus(ifo));
  uart_tx #(.PARITY_EN(1'b0)) dut_n (.clk_2br(clk), .reset(reset), .bus(ifn));

  assign ife.tx_valid = vld[0];
  assign ife.tx_data  = dat[0];
  assign ifo.tx_valid = vld[1];
  assign ifo.tx_data  = dat[1];
  assign ifn.tx_valid = vld[2];
  assign ifn.tx_data  = dat[2];

  assign o_tx[0]   = ife.tx;
  assign o_tx[1]   = ifo.tx;
  assign o_tx[2]   = ifn.tx;
  assign o_rdy[0]  = ife.tx_ready;
  assign o_rdy[1]  = ifo.tx_ready;
  assign o_rdy[2]  = ifn.tx_ready;
  assign o_busy[0] = ife.busy;
  assign o_busy[1] = ifo.busy;
  assign o_busy[2] = ifn.busy;
  assign o_done[0] = ife.done;
  assign o_done[1] = ifo.done;
  assign o_done[2] = ifn.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame literals: bit 0 = start, bits 8:1 = data, then parity (if any) and stop.
  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [10:0] frame;
    int         nbits;
    string      name;
  } vec_t;

  vec_t vecs [7];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input int sel, input string nm);
    chk1({nm, " tx"}, o_tx[sel], 1'b1);
    chk1({nm, " ready"}, o_rdy[sel], 1'b1);
    chk1({nm, " busy"}, o_busy[sel], 1'b0);
    chk1({nm, " done"}, o_done[sel], 1'b0);
  endtask

  // Present a byte and let the next rising edge accept it.
  task automatic accept(input int sel, input logic [7:0] d, input string nm);
    @(negedge clk);
    vld[sel] = 1'b1;
    dat[sel] = d;
    chk1({nm, " ready before accept"}, o_rdy[sel], 1'b1);
    chk1({nm, " done before accept"}, o_done[sel], 1'b0);
    @(posedge clk);
  endtask

  // Called right after the accept edge; checks every frame cycle and the done cycle.
  task automatic check_frame(input int sel, input logic [10:0] frame, input int nbits,
                             input bit drop, input int tog_c, input logic [7:0] tog_d,
                             input string nm);
    for (int c = 0; c < 2 * nbits; c++) begin
      @(negedge clk);
      if (c == 0 && drop) vld[sel] = 1'b0;
      if (c == tog_c) dat[sel] = tog_d;
      chk1($sformatf("%s tx c%0d", nm, c), o_tx[sel], frame[c/2]);
      chk1($sformatf("%s busy c%0d", nm, c), o_busy[sel], 1'b1);
      chk1($sformatf("%s ready c%0d", nm, c), o_rdy[sel], 1'b0);
      chk1($sformatf("%s done c%0d", nm, c), o_done[sel], 1'b0);
    end
    @(negedge clk);
    chk1({nm, " done pulse"}, o_done[sel], 1'b1);
    chk1({nm, " ready at end"}, o_rdy[sel], 1'b1);
    chk1({nm, " busy at end"}, o_busy[sel], 1'b0);
    chk1({nm, " tx idle at end"}, o_tx[sel], 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] rx;

    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{0, 8'hA5, 11'b1_0_1010_0101_0, 11, "even_a5"};
    vecs[1] = '{0, 8'h00, 11'b1_0_0000_0000_0, 11, "even_00"};
    vecs[2] = '{0, 8'h07, 11'b1_1_0000_0111_0, 11, "even_07"};
    vecs[3] = '{1, 8'h01, 11'b1_0_0000_0001_0, 11, "odd_01"};
    vecs[4] = '{1, 8'h00, 11'b1_1_0000_0000_0, 11, "odd_00"};
    vecs[5] = '{2, 8'hFF, 11'b0_1_1111_1111_0, 10, "nopar_ff"};
    vecs[6] = '{2, 8'h3C, 11'b0_1_0011_1100_0, 10, "nopar_3c"};

    for (int s = 0; s < 3; s++) begin
      vld[s] = 1'b0;
      dat[s] = 8'h00;
    end

    // Reset idle
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) check_idle(s, $sformatf("reset dut%0d", s));
    end
    reset = 1'b0;
    repeat (30) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) check_idle(s, $sformatf("idle dut%0d", s));
    end

    foreach (vecs[i]) begin
      accept(vecs[i].sel, vecs[i].data, vecs[i].name);
      check_frame(vecs[i].sel, vecs[i].frame, vecs[i].nbits, 1'b1, -1, 8'h00, vecs[i].name);
    end

    // Back-to-back with tx_data toggled mid-frame; the done cycle is the single idle gap.
    accept(0, 8'h00, "b2b_first");
    check_frame(0, 11'b1_0_0000_0000_0, 11, 1'b0, 5, 8'hFF, "b2b_first");
    @(posedge clk);
    check_frame(0, 11'b1_0_1111_1111_0, 11, 1'b1, -1, 8'h00, "b2b_second");

    // Accept and reset in the same cycle
    @(negedge clk);
    reset    = 1'b1;
    vld[0]   = 1'b1;
    dat[0]   = 8'hA5;
    @(negedge clk);
    reset  = 1'b0;
    vld[0] = 1'b0;
    check_idle(0, "same_cycle_reset");
    @(negedge clk);
    check_idle(0, "same_cycle_after");

    // Reset during data bit 3 of 0x55
    accept(0, 8'h55, "rst_mid");
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c == 0) vld[0] = 1'b0;
    end
    chk1("rst_mid busy before reset", o_busy[0], 1'b1);
    chk1("rst_mid tx bit3 before reset", o_tx[0], 1'b0);
    reset = 1'b1;
    #1;
    check_idle(0, "rst_mid async");
    @(negedge clk);
    chk1("rst_mid done held", o_done[0], 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_idle(0, "rst_mid released");
    accept(0, 8'h3C, "after_rst");
    check_frame(0, 11'b1_0_0011_1100_0, 11, 1'b1, -1, 8'h00, "after_rst");

    // Loopback: a receiver enabled in the second half of each bit recovers the byte.
    for (int n = 0; n < 256; n++) begin
      b  = 8'($urandom_range(0, 255));
      rx = 8'h00;
      accept(0, b, "loop");
      for (int c = 0; c < 22; c++) begin
        @(negedge clk);
        if (c == 0) vld[0] = 1'b0;
        if (c >= 3 && c <= 17 && (c % 2) == 1) rx[(c-3)/2] = o_tx[0];
      end
      chk8($sformatf("loop byte %0d", n), rx, b);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART full-duplex path; counterpart of the existing receiver state machine. It accepts one byte through a valid/ready handshake and serialises a frame on `tx`: start bit, 8 data bits LSB first, optional parity bit, one stop bit. It runs on the same 2×-baud clock as the receiver and holds every bit for two clock cycles, so a frame from this block is sampled correctly by the receiver's mid-bit enable.

## Interface
- `PARITY_EN`, default 1: 1 inserts a parity bit after b7; 0 omits it.
- `PARITY_ODD`, default 0: 0 selects even parity (parity bit = XOR of data); 1 selects odd parity (inverted XOR).
- `clk_2br`  in  1  clock at 2× baud rate; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_data`  in  8  byte to send; sampled only on accept.
- `tx_ready`  out  1  high exactly while the FSM is in IDLE.
- `tx`  out  1  serial line, registered, idle-high.
- `busy`  out  1  high from the cycle after accept until the frame ends (inverse of `tx_ready`).
- `done`  out  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Each non-IDLE state splits into two halves through a 1-bit `phase` register (0 = first half, 1 = second half). A 3-bit `bit_idx` selects the data bit.
- IDLE: `tx`=1. On `tx_valid & tx_ready`, latch `tx_data` into an 8-bit shift/hold register, compute parity from the latched byte, and go to START with phase 0.
- START: `tx`=0 for both halves, then go to DATA with bit_idx=0.
- DATA: `tx`=data[bit_idx] for both halves. After phase 1, increment bit_idx. After bit 7 (bit_idx=7, phase 1), go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: `tx`=parity bit for both halves, then go to STOP.
- STOP: `tx`=1 for both halves. After phase 1, go to IDLE and assert `done` for one cycle.
- `tx_valid` while busy is ignored. There is no queuing, and the request must stay asserted until it is accepted.
- Changes on `tx_data` after accept do not affect the frame in flight.
- An illegal state encoding recovers to IDLE on the next edge with `tx`=1.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `busy`=0, `done`=0. The FSM is in IDLE with phase=0, bit_idx=0, and the hold register cleared.
- Accept at edge k. `tx` falls after edge k.
  - Start bit occupies cycles k..k+1.
  - Data bit i occupies cycles k+2+2i and k+3+2i.
  - Parity (if enabled) occupies k+18..k+19.
  - Stop bit occupies k+20..k+21, or k+18..k+19 without parity.
- Frame length: 22 cycles (11 bits) with parity, 20 cycles without.
- At edge k+22 (or k+20) the FSM returns to IDLE: `tx_ready`=1, `busy`=0, `done`=1 for that one cycle.
- Back-to-back: with `tx_valid` held, the next accept happens at edge k+23. This inserts one idle-high cycle (half a bit) between frames, giving a minimum frame period of 23 cycles (21 without parity).
- `tx` is glitch-free because it comes directly from a flop.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronously) and all state clears. The partial frame is abandoned and `done` does not pulse. After reset deasserts, the first possible accept is at the next rising edge.
- Accept and reset in the same cycle: reset wins and no frame starts.

## Test plan
- **Reset idle:** assert `reset` for 3 cycles, then release and hold `tx_valid`=0 for 30 cycles. Required: `tx`=1, `tx_ready`=1, `busy`=0, `done`=0 throughout.
- **Single frame, even parity:** send `tx_data`=0xA5 with a one-cycle `tx_valid`. Required `tx` sequence, each level held 2 cycles: 0, 1,0,1,0,0,1,0,1, 0 (parity, four ones), 1. Then `done`=1 for exactly one cycle at edge k+22.
- **Odd parity / no parity:** with PARITY_ODD=1, send 0x01; the parity slot must be 0. With PARITY_EN=0, send 0xFF; the frame is 20 cycles and the stop bit follows b7 directly.
- **Back-to-back with data change:** hold `tx_valid`=1 and send 0x00 then 0xFF, toggling `tx_data` mid-frame. Required: first frame is unaffected by the toggle, second accept occurs at edge k+23, and one idle-high cycle appears between the frames.
- **Reset mid-frame:** assert `reset` during data bit 3 of 0x55. Required: `tx`=1 immediately, `busy`=0, no `done` pulse. A following send of 0x3C produces a clean full frame.
- **Loopback:** connect `tx` to the receiver's `rx` on the same `clk_2br`. Required: the receiver's enable pulses land in the second half of every data bit, and the sampled byte equals the sent byte for 256 random values.
